// File: rtl/fir_partial_mac.sv
// fir_partial_mac: time-multiplexed 10-tap signed MAC for one FIR delay group.
// Ports: iClk12M/iRst (sync, active-high), iEnSample600k strobe, iDelay tap
// group (tap k at [3k+2:3k]), iCoeffWrEn/iCoeffAddr/iCoeffData coefficient
// write port, oMac partial sum, oMacValid result pulse, oBusy, oOverrun pulse.
module fir_partial_mac #(
    parameter int SAMPLE_W = 3,
    parameter int COEFF_W  = 16,
    parameter int NTAP     = 10,
    parameter int ACC_W    = 23
) (
    input  logic                       iClk12M,
    input  logic                       iRst,
    input  logic                       iEnSample600k,
    input  logic [NTAP*SAMPLE_W-1:0]   iDelay,
    input  logic                       iCoeffWrEn,
    input  logic [3:0]                 iCoeffAddr,
    input  logic signed [COEFF_W-1:0]  iCoeffData,
    output logic signed [ACC_W-1:0]    oMac,
    output logic                       oMacValid,
    output logic                       oBusy,
    output logic                       oOverrun
);

    localparam int PROD_W = SAMPLE_W + COEFF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t                     state;
    logic [3:0]                 idx;
    logic signed [ACC_W-1:0]    acc;
    logic [NTAP*SAMPLE_W-1:0]   shadow;
    logic signed [COEFF_W-1:0]  coeff [NTAP];

    logic signed [SAMPLE_W-1:0] tap;
    logic signed [COEFF_W-1:0]  cf;
    logic signed [PROD_W-1:0]   tapx;
    logic signed [PROD_W-1:0]   cfx;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prodx;
    logic signed [ACC_W-1:0]    acc_nxt;

    // Select the current tap/coefficient pair for the single shared multiplier.
    always_comb begin
        tap = '0;
        cf  = '0;
        for (int k = 0; k < NTAP; k++) begin
            if (idx == 4'(k)) begin
                tap = shadow[k*SAMPLE_W +: SAMPLE_W];
                cf  = coeff[k];
            end
        end
    end

    // Both operands widened to the full product width so the low PROD_W
    // bits of the product are the exact signed result.
    always_comb begin
        tapx    = {{COEFF_W{tap[SAMPLE_W-1]}}, tap};
        cfx     = {{SAMPLE_W{cf[COEFF_W-1]}}, cf};
        prod    = tapx * cfx;
        prodx   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_nxt = acc + prodx;
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state     <= S_IDLE;
            idx       <= '0;
            acc       <= '0;
            shadow    <= '0;
            oMac      <= '0;
            oMacValid <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
            for (int k = 0; k < NTAP; k++) coeff[k] <= '0;
        end else begin
            oMacValid <= 1'b0;
            oOverrun  <= 1'b0;

            // Coefficients only change between sums.
            if (iCoeffWrEn && state == S_IDLE) begin
                for (int k = 0; k < NTAP; k++) begin
                    if (iCoeffAddr == 4'(k)) coeff[k] <= iCoeffData;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (iEnSample600k) begin
                        shadow <= iDelay;
                        acc    <= '0;
                        idx    <= '0;
                        oBusy  <= 1'b1;
                        state  <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (iEnSample600k) oOverrun <= 1'b1;
                    acc <= acc_nxt;
                    if (idx == 4'(NTAP-1)) begin
                        oMac      <= acc_nxt;
                        oMacValid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_DONE: begin
                    if (iEnSample600k) oOverrun <= 1'b1;
                    oBusy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_partial_mac.sv
// tb_fir_partial_mac: randomized and directed checks of fir_partial_mac
// against an arithmetic reference model of the tap-group sum.
`timescale 1ns/1ps
module tb_fir_partial_mac;

    localparam int NTAP = 10;

    logic              iClk12M = 1'b0;
    logic              iRst = 1'b1;
    logic              iEnSample600k = 1'b0;
    logic [29:0]       iDelay = '0;
    logic              iCoeffWrEn = 1'b0;
    logic [3:0]        iCoeffAddr = '0;
    logic signed [15:0] iCoeffData = '0;
    logic signed [22:0] oMac;
    logic              oMacValid;
    logic              oBusy;
    logic              oOverrun;

    int n_cmp = 0;
    int n_bad = 0;
    int m_coef [NTAP];
    int m_mac = 0;
    logic [29:0] taps_alt;

    fir_partial_mac dut (
        .iClk12M      (iClk12M),
        .iRst         (iRst),
        .iEnSample600k(iEnSample600k),
        .iDelay       (iDelay),
        .iCoeffWrEn   (iCoeffWrEn),
        .iCoeffAddr   (iCoeffAddr),
        .iCoeffData   (iCoeffData),
        .oMac         (oMac),
        .oMacValid    (oMacValid),
        .oBusy        (oBusy),
        .oOverrun     (oOverrun)
    );

    always #5 iClk12M = ~iClk12M;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk12M);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        iCoeffWrEn = 1'b1;
        iCoeffAddr = a;
        iCoeffData = d;
        tick;
        iCoeffWrEn = 1'b0;
        if (int'(a) < NTAP) m_coef[a] = int'($signed(d));
    endtask

    function automatic int model_sum(input logic [29:0] taps);
        int s;
        logic signed [2:0] t;
        s = 0;
        for (int k = 0; k < NTAP; k++) begin
            t = taps[3*k +: 3];
            s += int'(t) * m_coef[k];
        end
        return s;
    endfunction

    // Strobe at T, then walk T+1..T+13 checking every output each cycle.
    task automatic run(input logic [29:0] taps, input int ovr_at,
                       input int wr_at, input int rst_at, input string tag);
        int  exp;
        bit  rst_done;
        rst_done = 1'b0;
        exp = model_sum(taps);
        iDelay = taps;
        iEnSample600k = 1'b1;
        tick;
        iEnSample600k = 1'b0;
        iDelay = 30'($urandom);
        for (int n = 1; n <= 13; n++) begin
            if (n == 11 && !rst_done) m_mac = exp;
            chk({tag, ".busy"}, int'(oBusy), int'(n <= 11 && !rst_done));
            chk({tag, ".valid"}, int'(oMacValid), int'(n == 11 && !rst_done));
            chk({tag, ".ovr"}, int'(oOverrun),
                int'(ovr_at != 0 && n == ovr_at + 1 && !rst_done));
            chk({tag, ".mac"}, int'(oMac), m_mac);
            iEnSample600k = 1'b0;
            iCoeffWrEn = 1'b0;
            iRst = 1'b0;
            if (n == ovr_at) iEnSample600k = 1'b1;
            if (n == wr_at) begin
                iCoeffWrEn = 1'b1;
                iCoeffAddr = 4'd0;
                iCoeffData = 16'sd100;
            end
            if (n == rst_at) begin
                iRst = 1'b1;
                rst_done = 1'b1;
                m_mac = 0;
                for (int k = 0; k < NTAP; k++) m_coef[k] = 0;
            end
            tick;
        end
        iEnSample600k = 1'b0;
        iCoeffWrEn = 1'b0;
        iRst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NTAP; k++) m_coef[k] = 0;
        iRst = 1'b1;
        tick;
        tick;
        iRst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk("idle.mac", int'(oMac), 0);
            chk("idle.valid", int'(oMacValid), 0);
            chk("idle.busy", int'(oBusy), 0);
            chk("idle.ovr", int'(oOverrun), 0);
            tick;
        end

        for (int k = 0; k < NTAP; k++) wr(4'(k), 16'sd1);
        run({10{3'b001}}, 0, 0, 0, "ones");
        chk("ones.exact", int'(oMac), 10);

        for (int k = 0; k < NTAP; k++) wr(4'(k), 16'sd32767);
        run({10{3'b100}}, 0, 0, 0, "maxpos");
        chk("maxpos.exact", int'(oMac), -1310680);

        for (int k = 0; k < NTAP; k++) wr(4'(k), 16'h8000);
        run({10{3'b100}}, 0, 0, 0, "maxneg");
        chk("maxneg.exact", int'(oMac), 1310720);

        for (int k = 0; k < NTAP; k++) wr(4'(k), 16'(k + 1));
        wr(4'd12, 16'sd999);
        for (int k = 0; k < NTAP; k++)
            taps_alt[3*k +: 3] = (k % 2 != 0) ? 3'b111 : 3'b001;
        run(taps_alt, 0, 0, 0, "alt");
        chk("alt.exact", int'(oMac), -5);

        run(taps_alt, 5, 3, 0, "ovr");
        chk("ovr.exact", int'(oMac), -5);
        run(taps_alt, 0, 0, 0, "oldcoef");
        chk("oldcoef.exact", int'(oMac), -5);

        run(taps_alt, 11, 0, 0, "donestb");

        run(taps_alt, 0, 0, 6, "rst");
        chk("rst.mac", int'(oMac), 0);
        run(taps_alt, 0, 0, 0, "postrst");
        chk("postrst.exact", int'(oMac), 0);

        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = int'($urandom_range(0, 6));
            for (int j = 0; j < nw; j++)
                wr(4'($urandom_range(0, 15)), 16'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 8)); g++) tick;
            run(30'($urandom), int'($urandom_range(0, 11)),
                int'($urandom_range(0, 11)), 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
